// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared constants and state encoding for the ChaCha keystream sequencer
package chacha_pkg;

  localparam int BLOCK_BYTES      = 64;
  localparam int CTR_BYTES        = 4;
  localparam int CTR_ADDR_DEFAULT = 48;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/chacha_keystream_ctrl.sv
// rtl/chacha_keystream_ctrl.sv - ChaCha block-core sequencer: counter load, wait, keystream streaming
// Optional feature macro: COUNTER_WRAP_ERR_EN (counter wrap inside a run raises sticky err)
module chacha_keystream_ctrl
  import chacha_pkg::*;
#(
  parameter int CTR_ADDR = CTR_ADDR_DEFAULT,
  parameter int NBLK_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [5:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic              cfg_busy,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       ctr_init,
  input  logic [NBLK_W-1:0] nblocks,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [7:0]        ks_data,
  output logic              ks_last,
  output logic              done,
  output logic              err,
  output logic              blk_write,
  output logic [5:0]        blk_addr,
  output logic [7:0]        blk_data_in,
  input  logic              blk_ready,
  input  logic [7:0]        blk_data_out
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);
  localparam logic [1:0] LAST_K   = 2'(CTR_BYTES - 1);

  state_t            state, state_n;
  logic [31:0]       ctr, ctr_n;
  logic [NBLK_W-1:0] remaining, remaining_n;
  logic [5:0]        idx, idx_n;
  logic [1:0]        ld_k, ld_k_n;
  logic              done_q, done_n;
  logic              block_end;

`ifdef COUNTER_WRAP_ERR_EN
  logic err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cfg_busy  = (state != ST_IDLE);
  assign done      = done_q;
  assign block_end = (state == ST_STREAM) && ks_ready && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctr       <= '0;
      remaining <= '0;
      idx       <= '0;
      ld_k      <= '0;
      done_q    <= 1'b0;
`ifdef COUNTER_WRAP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ctr       <= ctr_n;
      remaining <= remaining_n;
      idx       <= idx_n;
      ld_k      <= ld_k_n;
      done_q    <= done_n;
`ifdef COUNTER_WRAP_ERR_EN
      err_q     <= err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    ctr_n       = ctr;
    remaining_n = remaining;
    idx_n       = idx;
    ld_k_n      = ld_k;
    done_n      = 1'b0;
`ifdef COUNTER_WRAP_ERR_EN
    err_n       = err_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          ctr_n       = ctr_init;
          remaining_n = nblocks;
          ld_k_n      = '0;
          if (nblocks == '0) done_n = 1'b1;
          else               state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_k_n = ld_k + 2'd1;
        if (ld_k == LAST_K) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (blk_ready) begin
          state_n = ST_STREAM;
          idx_n   = '0;
        end
      end
      ST_STREAM: begin
        if (ks_ready) idx_n = idx + 6'd1;
        if (block_end) begin
          remaining_n = remaining - NBLK_W'(1);
          ctr_n       = ctr + 32'd1;
          ld_k_n      = '0;
          if (remaining == NBLK_W'(1)) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
`ifdef COUNTER_WRAP_ERR_EN
          else if (ctr == 32'hFFFF_FFFF) begin
            err_n   = 1'b1;
            state_n = ST_ERR;
          end
`endif
          else begin
            state_n = ST_LOAD;
          end
        end
      end
`ifdef COUNTER_WRAP_ERR_EN
      ST_ERR: ;
`endif
      default: state_n = ST_IDLE;
    endcase

    // Abort wins over everything; the core is left mid-computation and rewritten on the next run
    if (stop && state != ST_IDLE) begin
      state_n = ST_IDLE;
      done_n  = 1'b1;
`ifdef COUNTER_WRAP_ERR_EN
      err_n   = 1'b0;
`endif
    end
  end

  always_comb begin
    blk_write   = 1'b0;
    blk_addr    = '0;
    blk_data_in = '0;
    ks_valid    = 1'b0;
    ks_data     = '0;
    ks_last     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_wr && !start) begin
          blk_write   = 1'b1;
          blk_addr    = cfg_addr;
          blk_data_in = cfg_data;
        end
      end
      ST_LOAD: begin
        blk_write   = 1'b1;
        blk_addr    = 6'(CTR_ADDR) + {4'd0, ld_k};
        blk_data_in = ctr[{ld_k, 3'b000} +: 8];
      end
      ST_STREAM: begin
        blk_addr = idx;
        ks_valid = 1'b1;
        ks_data  = blk_data_out;
        ks_last  = (idx == LAST_IDX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// tb/tb_chacha_keystream_ctrl.sv - self-checking bench with a behavioural ChaCha core and keystream scoreboard
module tb_chacha_keystream_ctrl;

  localparam int CORE_LAT = 30;

  logic        clk = 1'b0;
  logic        rst, cfg_wr, cfg_busy, start, stop;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [31:0] ctr_init;
  logic [15:0] nblocks;
  logic        ks_valid, ks_ready, ks_last, done, err;
  logic [7:0]  ks_data;
  logic        blk_write, blk_ready;
  logic [5:0]  blk_addr;
  logic [7:0]  blk_data_in, blk_data_out;

  always #5 clk = ~clk;

  chacha_keystream_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .start(start), .stop(stop), .ctr_init(ctr_init), .nblocks(nblocks),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
    .done(done), .err(err), .blk_write(blk_write), .blk_addr(blk_addr),
    .blk_data_in(blk_data_in), .blk_ready(blk_ready), .blk_data_out(blk_data_out)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha(input logic [511:0] s);
    logic [31:0] w[16];
    logic [31:0] x[16];
    logic [127:0] t;
    logic [511:0] o;
    int a, b, c, d, p;
    for (int i = 0; i < 16; i++) begin w[i] = s[32*i +: 32]; x[i] = w[i]; end
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        if (q < 4) begin a = q; b = q + 4; c = q + 8; d = q + 12; end
        else begin p = q - 4; a = p; b = 4 + (p + 1) % 4; c = 8 + (p + 2) % 4; d = 12 + (p + 3) % 4; end
        t = qr(x[a], x[b], x[c], x[d]);
        x[a] = t[127:96]; x[b] = t[95:64]; x[c] = t[63:32]; x[d] = t[31:0];
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + w[i];
    return o;
  endfunction

  // Host-side initial state: constants, RFC 8439 2.3.2 key and nonce, counter bytes zero
  logic [511:0] base;
  initial begin
    base = '0;
    base[127:0] = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    for (int i = 0; i < 32; i++) base[8*(16+i) +: 8] = 8'(i);
    base[8*55 +: 8] = 8'h09;
    base[8*59 +: 8] = 8'h4a;
  end

  function automatic logic [511:0] with_ctr(input logic [31:0] c);
    logic [511:0] t;
    t = base;
    t[415:384] = c;
    return t;
  endfunction

  // Behavioural block core: byte-addressed state, result appears CORE_LAT cycles after the last write
  logic [511:0] cmem = '0, cout = '0;
  logic         core_rdy;
  int           core_cnt;
  always @(posedge clk) begin
    if (rst) begin
      core_rdy <= 1'b0;
      core_cnt <= 0;
    end else if (blk_write) begin
      cmem[8*blk_addr +: 8] <= blk_data_in;
      core_rdy <= 1'b0;
      core_cnt <= CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        cout     <= chacha(cmem);
        core_rdy <= 1'b1;
      end
    end
  end
  assign blk_ready    = core_rdy;
  assign blk_data_out = core_rdy ? cout[8*blk_addr +: 8] : 8'h00;

  // Scoreboard: expected counter writes {addr,data} and keystream {last,data}
  logic [13:0] exp_ld[$];
  logic [8:0]  exp_ks[$];
  int          cyc = 0, acc_cnt = 0, last_acc = 0, done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (blk_write && cfg_busy) begin
        if (exp_ld.size() == 0) chk("load_extra", 64'(exp_ld.size()), 1);
        else chk("load_byte", {blk_addr, blk_data_in}, exp_ld.pop_front());
      end
      if (ks_valid) begin
        if (prev_stall) chk("stall_stable", {ks_last, ks_data}, prev_word);
        if (ks_ready) begin
          if (exp_ks.size() == 0) chk("ks_extra", 64'(exp_ks.size()), 1);
          else chk("ks_byte", {ks_last, ks_data}, exp_ks.pop_front());
          acc_cnt++;
          last_acc = cyc;
        end
      end
      prev_stall = ks_valid && !ks_ready;
      prev_word  = {ks_last, ks_data};
      if (done) done_cnt++;
    end
  end

  // Consumer: always ready or random 50%, never past rdy_limit accepted bytes
  int rdy_mode = 0;
  int rdy_limit = 1000000;
  initial begin
    ks_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ks_ready = (acc_cnt < rdy_limit) && (rdy_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic expect_run(input logic [31:0] c0, input int n, input int limit);
    logic [31:0]  c;
    logic [511:0] ks;
    int cnt;
    cnt = 0;
    for (int b = 0; b < n; b++) begin
      c = c0 + 32'(b);
      for (int k = 0; k < 4; k++) exp_ld.push_back({6'(48 + k), c[8*k +: 8]});
      ks = chacha(with_ctr(c));
      for (int i = 0; i < 64; i++)
        if (cnt < limit) begin
          exp_ks.push_back({i == 63, ks[8*i +: 8]});
          cnt++;
        end
    end
  endtask

  task automatic pulse_start(input logic [31:0] c0, input logic [15:0] n);
    @(posedge clk); #1;
    ctr_init = c0; nblocks = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_blocks(input logic [31:0] c0, input int n);
    int d0;
    expect_run(c0, n, 64 * n);
    d0 = done_cnt;
    pulse_start(c0, 16'(n));
    for (int t = 0; t < 5000 && !done; t++) tick();
    chk("done_seen", done, 1);
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("done_latency", 64'(cyc - last_acc), 1);
    chk("ks_left", 64'(exp_ks.size()), 0);
    chk("ld_left", 64'(exp_ld.size()), 0);
  endtask

  initial begin
    logic [511:0] ks1;
    int d0, target;
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; ctr_init = '0; nblocks = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle outputs and combinational config pass-through
    tick();
    chk("reset_outputs", {cfg_busy, ks_valid, ks_last, done, err, blk_write, blk_addr, blk_data_in, ks_data}, 0);
    cfg_wr = 1'b1; cfg_addr = 6'd16; cfg_data = 8'hA5;
    #1 chk("cfg_pass", {blk_write, blk_addr, blk_data_in}, {1'b1, 6'd16, 8'hA5});
    @(posedge clk); #1 cfg_wr = 1'b0;

    for (int a = 0; a < 64; a++) begin
      if (a >= 48 && a < 52) continue;
      @(posedge clk); #1;
      cfg_wr = 1'b1; cfg_addr = 6'(a); cfg_data = base[8*a +: 8];
    end
    @(posedge clk); #1 cfg_wr = 1'b0;

    // Model pinned to RFC 8439 2.3.2 keystream head
    ks1 = chacha(with_ctr(32'd1));
    chk("rfc_head", ks1[63:0], 64'h15593bd1e4e7f110);

    // 2: one block, counter 1
    run_blocks(32'd1, 1);

    // nblocks=0 with a simultaneous cfg write: start wins, done next cycle, no core write
    d0 = done_cnt;
    @(posedge clk); #1;
    ctr_init = 32'd5; nblocks = 16'd0; start = 1'b1;
    cfg_wr = 1'b1; cfg_addr = 6'd0; cfg_data = 8'hEE;
    #1 chk("start_wins", blk_write, 0);
    @(posedge clk); #1 start = 1'b0; cfg_wr = 1'b0;
    tick();
    chk("n0_done", done, 1);
    chk("n0_busy", cfg_busy, 0);
    tick();
    chk("n0_done_once", 64'(done_cnt - d0), 1);

    // 3: three blocks starting at counter 7
    run_blocks(32'd7, 3);

    // 4: random backpressure
    rdy_mode = 1;
    run_blocks(32'd1, 1);
    rdy_mode = 0;

    // 5: stop with idx=20 on the bus, then a clean rerun
    expect_run(32'd1, 1, 20);
    target = acc_cnt + 20;
    rdy_limit = target;
    pulse_start(32'd1, 16'd1);
    for (int t = 0; t < 2000 && acc_cnt < target; t++) tick();
    chk("stop_reach", 64'(acc_cnt), 64'(target));
    @(posedge clk); #1 stop = 1'b1;
    tick();
    chk("stop_valid_before", ks_valid, 1);
    chk("stop_idx20_data", ks_data, ks1[8*20 +: 8]);
    @(posedge clk); #1 stop = 1'b0;
    tick();
    chk("stop_done", done, 1);
    chk("stop_valid_drop", ks_valid, 0);
    chk("stop_idle", cfg_busy, 0);
    rdy_limit = 1000000;
    chk("stop_ks_left", 64'(exp_ks.size()), 0);
    run_blocks(32'd1, 1);

    // 6: counter wrap inside a run
`ifdef COUNTER_WRAP_ERR_EN
    expect_run(32'hFFFF_FFFF, 1, 64);
    d0 = done_cnt;
    pulse_start(32'hFFFF_FFFF, 16'd2);
    for (int t = 0; t < 2000 && !err; t++) tick();
    chk("wrap_err", err, 1);
    repeat (10) tick();
    chk("wrap_err_sticky", err, 1);
    chk("wrap_no_done", 64'(done_cnt - d0), 0);
    chk("wrap_ld_left", 64'(exp_ld.size()), 0);
    chk("wrap_ks_left", 64'(exp_ks.size()), 0);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    tick();
    chk("wrap_stop_done", done, 1);
    chk("wrap_err_clear", err, 0);
`else
    run_blocks(32'hFFFF_FFFF, 2);
    chk("wrap_err_tied", err, 0);
`endif

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
